// File: rtl/vend_pkg.sv
// Shared types and default parameters for the coin vending controller.
//   state_e    : controller state (binary encoded)
//   coin_sel_e : which coin input won the priority select this cycle
package vend_pkg;

    localparam int unsigned DEF_VAL_A      = 5;
    localparam int unsigned DEF_VAL_B      = 10;
    localparam int unsigned DEF_VAL_C      = 25;
    localparam int unsigned DEF_PRICE      = 15;
    localparam int unsigned DEF_MAX_CREDIT = 55;
    localparam int unsigned DEF_CREDIT_W   = 6;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_VEND    = 3'd2,
        S_CHANGE  = 3'd3,
        S_REFUND  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_A    = 2'd1,
        COIN_B    = 2'd2,
        COIN_C    = 2'd3
    } coin_sel_e;

endpackage

// File: rtl/change_dispenser.sv
// Greedy one-coin-per-cycle pay-out decision, shared by CHANGE and REFUND.
// Ports:
//   credit    in   credit still owed to the customer
//   chg_b     out  pay one B coin this cycle
//   chg_a     out  pay one A coin this cycle
//   decrement out  amount paid this cycle (0 when nothing can be paid)
//   done      out  nothing payable remains after this cycle
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned VAL_A    = DEF_VAL_A,
    parameter int unsigned VAL_B    = DEF_VAL_B,
    parameter int unsigned CREDIT_W = DEF_CREDIT_W
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic                chg_b,
    output logic                chg_a,
    output logic [CREDIT_W-1:0] decrement,
    output logic                done
);

    localparam logic [CREDIT_W-1:0] A_C = CREDIT_W'(VAL_A);
    localparam logic [CREDIT_W-1:0] B_C = CREDIT_W'(VAL_B);

    logic [CREDIT_W-1:0] remain;

    // Largest coin first; a remainder below VAL_A cannot be paid and ends the pay-out.
    always_comb begin
        chg_b     = 1'b0;
        chg_a     = 1'b0;
        decrement = '0;
        if (credit >= B_C) begin
            chg_b     = 1'b1;
            decrement = B_C;
        end else if (credit >= A_C) begin
            chg_a     = 1'b1;
            decrement = A_C;
        end
        remain = credit - decrement;
        done   = (remain < A_C);
    end

endmodule

// File: rtl/coin_vend_ctrl.sv
// Coin vending controller: accumulates credit from coins A/B/C, vends one
// item at PRICE, pays change / refunds as A and B coin pulses.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   a_in, b_in, c_in    single-cycle coin pulses from the validator
//   cancel              refund request (level)
//   collect, vend       1-cycle pulses: escrow to cashbox, dispense item
//   chg_a_out/chg_b_out 1-cycle pulses: eject one A / B coin
//   coin_rej            this cycle's coin(s) go to the return chute (combinational)
//   busy                high in VEND, CHANGE, REFUND
//   credit              current credit (registered)
module coin_vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned VAL_A      = DEF_VAL_A,
    parameter int unsigned VAL_B      = DEF_VAL_B,
    parameter int unsigned VAL_C      = DEF_VAL_C,
    parameter int unsigned PRICE      = DEF_PRICE,
    parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT,
    parameter int unsigned CREDIT_W   = DEF_CREDIT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_in,
    input  logic                b_in,
    input  logic                c_in,
    input  logic                cancel,
    output logic                collect,
    output logic                vend,
    output logic                chg_a_out,
    output logic                chg_b_out,
    output logic                coin_rej,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam int unsigned SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0]    MAX_S   = SUM_W'(MAX_CREDIT);
    localparam logic [SUM_W-1:0]    PRICE_S = SUM_W'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    // Change is only payable if every amount is a whole number of A coins.
    if ((VAL_A == 0) || (VAL_B % VAL_A != 0) || (VAL_C % VAL_A != 0) ||
        (PRICE % VAL_A != 0) || (MAX_CREDIT % VAL_A != 0)) begin : g_bad_multiple
        $error("coin_vend_ctrl: VAL_B, VAL_C, PRICE, MAX_CREDIT must be multiples of VAL_A");
    end
    if ((MAX_CREDIT >> CREDIT_W) != 0) begin : g_bad_width
        $error("coin_vend_ctrl: MAX_CREDIT does not fit in CREDIT_W bits");
    end

    state_e              state, state_d;
    logic [CREDIT_W-1:0] credit_d;

    coin_sel_e           coin_sel;
    logic [SUM_W-1:0]    coin_val;
    logic [SUM_W-1:0]    sum;
    logic                any_coin, multi_coin, coin_fits, hits_price;

    logic                disp_b, disp_a, disp_done;
    logic [CREDIT_W-1:0] disp_dec;

    change_dispenser #(
        .VAL_A    (VAL_A),
        .VAL_B    (VAL_B),
        .CREDIT_W (CREDIT_W)
    ) u_disp (
        .credit    (credit),
        .chg_b     (disp_b),
        .chg_a     (disp_a),
        .decrement (disp_dec),
        .done      (disp_done)
    );

    // Coin priority C > B > A and the candidate sum, one bit wider so it cannot wrap.
    always_comb begin
        coin_sel = COIN_NONE;
        coin_val = '0;
        if (c_in) begin
            coin_sel = COIN_C;
            coin_val = SUM_W'(VAL_C);
        end else if (b_in) begin
            coin_sel = COIN_B;
            coin_val = SUM_W'(VAL_B);
        end else if (a_in) begin
            coin_sel = COIN_A;
            coin_val = SUM_W'(VAL_A);
        end
        sum        = {1'b0, credit} + coin_val;
        coin_fits  = (sum <= MAX_S);
        hits_price = (sum >= PRICE_S);
        any_coin   = a_in | b_in | c_in;
        multi_coin = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);
    end

    // State and credit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            credit <= '0;
        end else begin
            state  <= state_d;
            credit <= credit_d;
        end
    end

    // Next state, next credit and outputs; pulses decode from registered state only.
    always_comb begin
        state_d   = state;
        credit_d  = credit;
        collect   = 1'b0;
        vend      = 1'b0;
        chg_a_out = 1'b0;
        chg_b_out = 1'b0;
        busy      = 1'b0;
        coin_rej  = any_coin;
        case (state)
            S_IDLE, S_COLLECT: begin
                coin_rej = multi_coin;
                if ((state == S_COLLECT) && cancel) begin
                    coin_rej = any_coin;
                    state_d  = S_REFUND;
                end else if (coin_sel != COIN_NONE) begin
                    if (coin_fits) begin
                        credit_d = CREDIT_W'(sum);
                        state_d  = hits_price ? S_VEND : S_COLLECT;
                    end else begin
                        coin_rej = 1'b1;
                    end
                end
            end
            S_VEND: begin
                busy     = 1'b1;
                vend     = 1'b1;
                collect  = 1'b1;
                credit_d = credit - PRICE_C;
                state_d  = (credit == PRICE_C) ? S_IDLE : S_CHANGE;
            end
            S_CHANGE, S_REFUND: begin
                busy      = 1'b1;
                chg_b_out = disp_b;
                chg_a_out = disp_a;
                credit_d  = credit - disp_dec;
                if (disp_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

endmodule
